// File: rtl/floppy_bank_if.sv
// Register-controller side of the floppy tone bank: indexed write port,
// per-channel homing requests and the drive connector lines.
interface floppy_bank_if #(
    parameter int NUM_DRIVES = 8,
    parameter int SP_WIDTH   = 22
);
    logic                  wr_en;
    logic [3:0]            wr_addr;
    logic [SP_WIDTH-1:0]   wr_sp;
    logic                  wr_enable;
    logic [NUM_DRIVES-1:0] home_req;
    logic [NUM_DRIVES-1:0] step;
    logic [NUM_DRIVES-1:0] dir;
    logic [NUM_DRIVES-1:0] sel;
    logic [NUM_DRIVES-1:0] busy;

    modport master (
        output wr_en, wr_addr, wr_sp, wr_enable, home_req,
        input  step, dir, sel, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_sp, wr_enable, home_req,
        output step, dir, sel, busy
    );
endinterface

// File: rtl/floppy_bank.sv
// N-channel floppy stepper tone generator: each channel plays a square wave on
// its step line, tracks head position with bounce at the limits, and can home.
module floppy_chan #(
    parameter int SP_WIDTH  = 22,
    parameter int MAX_TRACK = 79,
    parameter int HOME_HALF = 250000,
    parameter int MIN_SP    = 2000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_hit,
    input  logic [SP_WIDTH-1:0] wr_sp,
    input  logic                wr_enable,
    input  logic                home_req,
    output logic                step,
    output logic                dir,
    output logic                sel,
    output logic                busy
);
    localparam int TW = (MAX_TRACK > 0) ? $clog2(MAX_TRACK + 1) : 1;
    localparam logic [TW-1:0]       TRK_MAX = TW'(MAX_TRACK);
    localparam logic [SP_WIDTH-1:0] SP_MIN  = SP_WIDTH'(MIN_SP);
    localparam logic [SP_WIDTH-1:0] HALF_M1 = SP_WIDTH'(HOME_HALF - 1);

    typedef enum logic [1:0] {IDLE, PLAY, HOME} state_t;

    state_t              state_q, state_d;
    logic [SP_WIDTH-1:0] sp_q, sp_d, cnt_q, cnt_d;
    logic                en_q, en_d;
    logic [TW-1:0]       track_q, track_d, hcnt_q, hcnt_d;
    logic                step_q, step_d, dir_q, dir_d, sel_q, sel_d, busy_q, busy_d;
    logic [TW-1:0]       trk_mv;
    logic                dir_mv, active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        track_d = track_q;
        hcnt_d  = hcnt_q;
        step_d  = step_q;
        dir_d   = dir_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        sp_d    = sp_q;
        en_d    = en_q;

        if (wr_hit) begin
            sp_d = (wr_sp == '0) ? '0 : ((wr_sp < SP_MIN) ? SP_MIN : wr_sp);
            en_d = wr_enable;
        end

        active = en_q && (sp_q != '0);

        // Head position after a falling step edge, with reversal at either stop.
        trk_mv = dir_q ? (track_q - TW'(1)) : (track_q + TW'(1));
        dir_mv = dir_q;
        if (trk_mv == TRK_MAX) dir_mv = 1'b1;
        else if (trk_mv == '0) dir_mv = 1'b0;

        if (home_req && state_q != HOME) begin
            state_d = HOME;
            cnt_d   = '0;
            hcnt_d  = '0;
            step_d  = 1'b0;
            dir_d   = 1'b1;
            sel_d   = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    step_d = 1'b0;
                    sel_d  = 1'b1;
                    busy_d = 1'b0;
                    if (active) begin
                        state_d = PLAY;
                        sel_d   = 1'b0;
                    end
                end
                PLAY: begin
                    if (!active) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        step_d  = 1'b0;
                        sel_d   = 1'b1;
                        if (step_q) begin
                            track_d = trk_mv;
                            dir_d   = dir_mv;
                        end
                    end else begin
                        sel_d = 1'b0;
                        // >= so a lowered setpoint wraps at once instead of running to overflow
                        if (cnt_q >= sp_q - SP_WIDTH'(1)) begin
                            cnt_d  = '0;
                            step_d = ~step_q;
                            if (step_q) begin
                                track_d = trk_mv;
                                dir_d   = dir_mv;
                            end
                        end else begin
                            cnt_d = cnt_q + SP_WIDTH'(1);
                        end
                    end
                end
                HOME: begin
                    busy_d = 1'b1;
                    sel_d  = 1'b0;
                    dir_d  = 1'b1;
                    if (cnt_q >= HALF_M1) begin
                        cnt_d  = '0;
                        step_d = ~step_q;
                        if (step_q) begin
                            // MAX_TRACK+1 falls guarantee the head reaches the track-0 stop
                            if (hcnt_q == TRK_MAX) begin
                                track_d = '0;
                                hcnt_d  = '0;
                                dir_d   = 1'b0;
                                busy_d  = 1'b0;
                                sel_d   = !active;
                                state_d = active ? PLAY : IDLE;
                            end else begin
                                hcnt_d = hcnt_q + TW'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + SP_WIDTH'(1);
                    end
                end
                default: state_d = HOME;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOME;
            cnt_q   <= '0;
            track_q <= '0;
            hcnt_q  <= '0;
            sp_q    <= '0;
            en_q    <= 1'b0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            sel_q   <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            track_q <= track_d;
            hcnt_q  <= hcnt_d;
            sp_q    <= sp_d;
            en_q    <= en_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign sel  = sel_q;
    assign busy = busy_q;
endmodule

module floppy_bank #(
    parameter int NUM_DRIVES = 8,
    parameter int SP_WIDTH   = 22,
    parameter int MAX_TRACK  = 79,
    parameter int HOME_HALF  = 250000,
    parameter int MIN_SP     = 2000
) (
    input logic           clk,
    input logic           rst,
    floppy_bank_if.slave  bus
);
    logic [NUM_DRIVES-1:0] step_v, dir_v, sel_v, busy_v;

    for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_ch
        floppy_chan #(
            .SP_WIDTH (SP_WIDTH),
            .MAX_TRACK(MAX_TRACK),
            .HOME_HALF(HOME_HALF),
            .MIN_SP   (MIN_SP)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_hit   (bus.wr_en && (bus.wr_addr == 4'(i))),
            .wr_sp    (bus.wr_sp),
            .wr_enable(bus.wr_enable),
            .home_req (bus.home_req[i]),
            .step     (step_v[i]),
            .dir      (dir_v[i]),
            .sel      (sel_v[i]),
            .busy     (busy_v[i])
        );
    end

    assign bus.step = step_v;
    assign bus.dir  = dir_v;
    assign bus.sel  = sel_v;
    assign bus.busy = busy_v;
endmodule

// File: tb/tb_floppy_bank.sv
// Bench for floppy_bank: an event-level model predicts every step edge (cycle,
// level, dir, sel, busy); a monitor pops and compares each edge the DUT makes.
module tb_floppy_bank;
  localparam int ND = 4, SPW = 22, MAXT = 3, HALF = 10, MINSP = 4;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HOME = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  floppy_bank_if #(.NUM_DRIVES(ND), .SP_WIDTH(SPW)) bus();
  floppy_bank #(.NUM_DRIVES(ND), .SP_WIDTH(SPW), .MAX_TRACK(MAXT),
                .HOME_HALF(HALF), .MIN_SP(MINSP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic s; logic d; logic l; logic b; } ev_t;
  ev_t q[ND][$];

  int m_mode[ND], m_next[ND], m_last[ND], m_sp[ND], m_track[ND], m_falls[ND];
  bit m_en[ND], m_step[ND], m_dir[ND];
  bit mon_on;
  int total = 0, bad = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampf(int sp);
    return (sp == 0) ? 0 : ((sp < MINSP) ? MINSP : sp);
  endfunction

  task automatic push(int i, int t, bit l, bit b);
    ev_t e;
    e.t = t; e.s = m_step[i]; e.d = m_dir[i]; e.l = l; e.b = b;
    q[i].push_back(e);
  endtask

  task automatic move_head(int i);
    m_track[i] = m_dir[i] ? m_track[i] - 1 : m_track[i] + 1;
    if (m_track[i] == MAXT) m_dir[i] = 1'b1;
    else if (m_track[i] == 0) m_dir[i] = 1'b0;
  endtask

  // Roll the model forward, queueing every step edge at or before cycle upto.
  task automatic advance(int i, int upto);
    while (m_mode[i] != M_IDLE && m_next[i] <= upto) begin
      int t;
      t = m_next[i];
      m_step[i] = ~m_step[i];
      if (m_mode[i] == M_PLAY) begin
        if (!m_step[i]) move_head(i);
        push(i, t, 1'b0, 1'b0);
        m_last[i] = t;
        m_next[i] = t + m_sp[i];
      end else begin
        m_next[i] = t + HALF;
        if (!m_step[i]) m_falls[i]++;
        if (!m_step[i] && m_falls[i] == MAXT + 1) begin
          m_track[i] = 0;
          m_dir[i] = 1'b0;
          if (m_en[i] && m_sp[i] != 0) begin
            m_mode[i] = M_PLAY; m_last[i] = t; m_next[i] = t + m_sp[i];
            push(i, t, 1'b0, 1'b0);
          end else begin
            m_mode[i] = M_IDLE;
            push(i, t, 1'b1, 1'b0);
          end
        end else begin
          push(i, t, 1'b0, 1'b1);
        end
      end
    end
  endtask

  task automatic run_to(int c);
    for (int i = 0; i < ND; i++) advance(i, c);
    while (cyc < c) begin @(negedge clk); #2; end
    for (int i = 0; i < ND; i++) begin
      total++;
      if (q[i].size() > 0 && q[i][0].t <= c) begin
        bad++;
        $display("FAIL missing_edge ch%0d: expected step=%0b at cyc %0d, not observed through %0d",
                 i, q[i][0].s, q[i][0].t, c);
        while (q[i].size() > 0 && q[i][0].t <= c) void'(q[i].pop_front());
      end
    end
  endtask

  task automatic check_outputs(string tag);
    for (int i = 0; i < ND; i++) begin
      int exp;
      exp = {m_step[i], m_dir[i], m_mode[i] == M_IDLE, m_mode[i] == M_HOME};
      chk($sformatf("%s_ch%0d{step,dir,sel,busy}", tag, i),
          int'({bus.step[i], bus.dir[i], bus.sel[i], bus.busy[i]}), exp);
    end
  endtask

  task automatic do_write(int addr, int sp, bit en);
    int w;
    w = cyc + 1;
    for (int i = 0; i < ND; i++) advance(i, w);
    if (addr < ND) begin
      int i, spc;
      i = addr; spc = clampf(sp);
      m_sp[i] = spc; m_en[i] = en;
      if (m_mode[i] == M_IDLE) begin
        if (en && spc != 0) begin
          m_mode[i] = M_PLAY; m_last[i] = w + 1; m_next[i] = w + 1 + spc;
        end
      end else if (m_mode[i] == M_PLAY) begin
        if (!(en && spc != 0)) begin
          m_mode[i] = M_IDLE;
          if (m_step[i]) begin
            m_step[i] = 1'b0;
            move_head(i);
            push(i, w + 1, 1'b1, 1'b0);
          end
        end else begin
          m_next[i] = (m_last[i] + spc > w + 1) ? m_last[i] + spc : w + 1;
        end
      end
    end
    bus.wr_en = 1'b1; bus.wr_addr = 4'(addr); bus.wr_sp = SPW'(sp); bus.wr_enable = en;
    @(negedge clk); #2;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_home(int ch, bit with_wr, int sp, bit en);
    int h;
    h = cyc + 1;
    for (int i = 0; i < ND; i++) advance(i, (i == ch) ? h - 1 : h);
    if (m_mode[ch] != M_HOME) begin
      m_dir[ch] = 1'b1;
      if (m_step[ch]) begin
        m_step[ch] = 1'b0;
        push(ch, h, 1'b0, 1'b1);
      end
      m_mode[ch] = M_HOME; m_falls[ch] = 0; m_next[ch] = h + HALF;
    end
    if (with_wr) begin
      m_sp[ch] = clampf(sp); m_en[ch] = en;
      bus.wr_en = 1'b1; bus.wr_addr = 4'(ch); bus.wr_sp = SPW'(sp); bus.wr_enable = en;
    end
    bus.home_req = ND'(1) << ch;
    @(negedge clk); #2;
    bus.home_req = '0;
    bus.wr_en = 1'b0;
  endtask

  task automatic monitor();
    logic [ND-1:0] prev;
    prev = bus.step;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        for (int i = 0; i < ND; i++) begin
          if (bus.step[i] !== prev[i]) begin
            total++;
            if (q[i].size() == 0) begin
              bad++;
              $display("FAIL step_edge ch%0d: unexpected edge to %0b at cyc %0d", i, bus.step[i], cyc);
            end else begin
              ev_t e;
              e = q[i].pop_front();
              if (e.t != cyc || e.s !== bus.step[i] || e.d !== bus.dir[i] ||
                  e.l !== bus.sel[i] || e.b !== bus.busy[i]) begin
                bad++;
                $display("FAIL step_edge ch%0d: got cyc=%0d step=%0b dir=%0b sel=%0b busy=%0b expected cyc=%0d step=%0b dir=%0b sel=%0b busy=%0b",
                         i, cyc, bus.step[i], bus.dir[i], bus.sel[i], bus.busy[i],
                         e.t, e.s, e.d, e.l, e.b);
              end
            end
          end
        end
      end
      prev = bus.step;
    end
  endtask

  initial begin
    int c0;
    bit found;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_sp = '0; bus.wr_enable = 1'b0; bus.home_req = '0;
    mon_on = 1'b1;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    #2;
    chk("reset_vals", int'({bus.step, bus.dir, bus.sel, bus.busy}), 16'h0FFF);

    for (int i = 0; i < ND; i++) begin
      m_mode[i] = M_HOME; m_step[i] = 0; m_dir[i] = 1; m_falls[i] = 0;
      m_sp[i] = 0; m_en[i] = 0; m_track[i] = 0; m_last[i] = 0;
    end
    c0 = cyc;
    for (int i = 0; i < ND; i++) m_next[i] = c0 + HALF;
    rst = 1'b0;
    run_to(c0 + 1);
    check_outputs("home_start");
    run_to(c0 + 90);
    check_outputs("home_done");

    // Ch1 plays at interval 5; runs long enough to bounce off both limits.
    do_write(1, 5, 1'b1);
    run_to(cyc + 3);
    check_outputs("ch1_play");
    run_to(cyc + 70);
    check_outputs("ch1_bounce");

    // Sub-minimum setpoint is clamped; sp=0 and en=0 both silence the channel.
    do_write(2, 1, 1'b1);
    run_to(cyc + 40);
    check_outputs("ch2_clamp");
    do_write(2, 0, 1'b1);
    run_to(cyc + 5);
    check_outputs("ch2_sp0");
    do_write(2, 6, 1'b1);
    run_to(cyc + 20);
    do_write(2, 6, 1'b0);
    run_to(cyc + 5);
    check_outputs("ch2_en0");

    do_write(5, 7, 1'b1);
    run_to(cyc + 30);
    check_outputs("addr5_ignored");

    for (int k = 0; k < 30; k++) begin
      int r, ch;
      r = $urandom_range(0, 9);
      ch = $urandom_range(0, ND - 1);
      if (r < 7)
        do_write((r == 6) ? $urandom_range(ND, 15) : ch, $urandom_range(0, 12),
                 $urandom_range(0, 5) != 0);
      else if (r == 7)
        do_home(ch, 1'b0, 0, 1'b0);
      run_to(cyc + $urandom_range(3, 30));
      check_outputs("rand");
    end

    // Disable ch1 in its high phase: the falling edge arrives one cycle later.
    do_write(1, 6, 1'b1);
    run_to(cyc + 100);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      advance(1, cyc + 1);
      if (m_mode[1] == M_PLAY && m_step[1]) found = 1'b1;
      else run_to(cyc + 1);
    end
    chk("ch1_high_found", int'(found), 1);
    do_write(1, 6, 1'b0);
    run_to(cyc + 4);
    check_outputs("ch1_disable");
    chk("ch1_disable_sel", int'(bus.sel[1]), 1);

    // Homing request with a simultaneous setpoint write, then resume at 8.
    do_write(1, 5, 1'b1);
    run_to(cyc + 15);
    do_home(1, 1'b1, 8, 1'b1);
    run_to(cyc + 3);
    check_outputs("ch1_homing");
    run_to(cyc + 90);
    check_outputs("ch1_rehomed");
    run_to(cyc + 40);
    check_outputs("ch1_play8");

    // Reset asserted mid-homing clears outputs without waiting for a clock.
    do_home(0, 1'b0, 0, 1'b0);
    run_to(cyc + 25);
    check_outputs("ch0_mid_home");
    mon_on = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_step", int'(bus.step), 0);
    chk("async_rst_dir",  int'(bus.dir),  4'hF);
    chk("async_rst_sel",  int'(bus.sel),  4'hF);
    chk("async_rst_busy", int'(bus.busy), 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/floppy_bank.md
Name: floppy_bank

Overview:
- Parametrised N-channel floppy stepper tone generator. Generalises the fixed six-drive, one-instance-per-drive arrangement into a single block.
- Adds per-channel head-position tracking with automatic direction reversal at the track limits, which keeps the heads off the end stops.
- Adds a per-channel homing sequence and an indexed write port.
- Sits between the register controller and the drive connector pins.

Parameters:
- NUM_DRIVES, 8: number of drive channels (1..16).
- SP_WIDTH, 22: width of the period setpoint.
- MAX_TRACK, 79: highest track index; head travel is 0..MAX_TRACK.
- HOME_HALF, 250000: half-period in clk cycles of the homing step square wave.
- MIN_SP, 2000: minimum non-zero setpoint; non-zero values below it are clamped to MIN_SP.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- wr_en  in  1  one-cycle write strobe.
- wr_addr  in  4  channel index; writes to indices >= NUM_DRIVES are ignored.
- wr_sp  in  SP_WIDTH  half-period setpoint in clk cycles; 0 = silent.
- wr_enable  in  1  channel enable written alongside the setpoint.
- home_req  in  NUM_DRIVES  per-channel homing request, level-sampled each cycle.
- step  out  NUM_DRIVES  step line; the head moves one track on each 1->0 edge.
- dir  out  NUM_DRIVES  1 = outward (toward track 0), 0 = inward.
- sel  out  NUM_DRIVES  drive select, active-low.
- busy  out  NUM_DRIVES  high while the channel is homing.

Behaviour:
- Per-channel registers:
  - sp (SP_WIDTH) and en, updated by writes.
  - Counter cnt (SP_WIDTH).
  - track (clog2(MAX_TRACK+1) bits).
  - state: IDLE, PLAY, HOME.
  - All outputs are registered.
- Reset (async), every channel:
  - state=HOME, cnt=0, track=0, sp=0, en=0.
  - step=0, dir=1, sel=1, busy=1.
  - Homing starts on the first clk edge after rst falls.
  - Assertion of rst mid-operation aborts everything and returns to these values.
- Writes:
  - Registered on the wr_en cycle: sp<=clamp(wr_sp), en<=wr_enable.
  - Take effect from the next cycle.
  - Clamp rule: 0 stays 0; 1..MIN_SP-1 becomes MIN_SP.
  - A write during HOME updates sp/en only; it is applied on HOME exit.
- IDLE:
  - Entered when en=0 or sp=0. cnt=0, step=0, sel=1.
  - Goes to PLAY on the cycle after en=1 and sp!=0.
- PLAY:
  - sel=0. cnt increments each cycle.
  - When cnt >= sp-1: cnt<=0 and step toggles. Using >= means a lowered sp wraps immediately.
  - Tone period is 2*sp cycles.
  - On each step 1->0 toggle, track moves by one in the dir direction in the same cycle.
  - At that same edge, if the new track equals MAX_TRACK, dir<=1; if it equals 0, dir<=0. Heads therefore bounce and never exceed 0..MAX_TRACK.
- Leaving PLAY (en=0 or sp=0):
  - If step=1, the next cycle drives step 0 and counts the edge as a track move, including bounce logic.
  - The channel then enters IDLE.
- HOME:
  - Entered from IDLE or PLAY when home_req[i]=1. home_req in HOME is ignored.
  - busy=1, sel=0, dir=1.
  - step toggles every HOME_HALF cycles, starting from step=0 and cnt=0.
  - Exactly MAX_TRACK+1 falling edges, which overdrives the head onto the track-0 stop.
  - track is not decremented during HOME.
  - After the last falling edge: track<=0, dir<=0, busy<=0, cnt<=0. Next state is PLAY if en && sp!=0, else IDLE.
- Simultaneous events:
  - home_req and a write to the same channel in the same cycle: the write is stored and HOME is entered.
  - A write and a step toggle in the same cycle: the toggle uses the old sp, the next compare uses the new sp.
- Channels are fully independent; no shared counters.

Test Plan:
- Bench parameters: NUM_DRIVES=4, MAX_TRACK=3, HOME_HALF=10, MIN_SP=4.
  - Pulse rst -> all busy=1, sel=0 from 1 cycle after release.
  - Each channel then gives exactly 4 step falling edges 20 cycles apart.
  - After the last edge: busy=0, dir=0, sel=1.
- After homing, write ch1 sp=5 en=1:
  - step[1] toggles every 5 cycles (period 10).
  - sel[1]=0; other channels unaffected.
- Continue ch1 play:
  - dir[1] flips to 1 at the 3rd falling edge (track=3) and back to 0 at the 6th (track=0).
  - track never leaves 0..3.
- Write ch2 sp=1 en=1:
  - Clamped to 4; step[2] toggles every 4 cycles.
  - Writes to ch2 with sp=0 or en=0 -> IDLE, step=0, sel=1.
- Disable ch1 while step[1]=1:
  - step[1] falls the next cycle, with a track update.
  - Then IDLE with sel=1.
- Write wr_addr=5 -> no channel changes.
- Pulse home_req[1] during PLAY with a simultaneous write sp=8:
  - Homing runs (4 edges).
  - Then PLAY resumes at a toggle interval of 8.
- Pulse rst mid-HOME -> outputs return to reset values asynchronously.
